// File: rtl/wb_pkg.sv
// Shared widths, writeback entry type and source-select encoding for the writeback arbiter.
package wb_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDRESS_WIDTH = 5;
    localparam int unsigned NUM_REGS      = 32;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0]    data;
    } wb_entry_t;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_FIFO = 2'd1;
    localparam logic [1:0] SEL_BYP  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

endpackage

// File: rtl/wb_fifo.sv
// Small ring-buffer FIFO of writeback entries with per-entry valid/dest taps.
// Occupancy is tracked by the valid bits alone, so full/empty need no separate counter.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   push_i,
    input  wb_entry_t                              push_entry_i,
    input  logic                                   pop_i,
    output wb_entry_t                              head_o,
    output logic                                   full_o,
    output logic                                   empty_o,
    output logic [DEPTH-1:0]                       entry_valid_o,
    output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0]    entry_dest_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (pop_i) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + 1'b1;
        end
        if (push_i) begin
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            if (push_i) begin
                mem_q[wptr_q] <= push_entry_i;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_dest_o[i] = mem_q[i].dest;
        end
    end

    assign head_o        = mem_q[rptr_q];
    assign full_o        = &valid_q;
    assign empty_o       = ~|valid_q;
    assign entry_valid_o = valid_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU pipe has priority, multi-cycle results are buffered or bypassed.
// Define WB_FWD_EN to add the write-to-read forwarding ports.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     alu_wb_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_wb_dest_i,
    input  logic [DATA_WIDTH-1:0]    alu_wb_data_i,
    input  logic                     mc_wb_valid_i,
    output logic                     mc_wb_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] mc_wb_dest_i,
    input  logic [DATA_WIDTH-1:0]    mc_wb_data_i,
    output logic                     rg_wrt_en_o,
    output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest_o,
    output logic [DATA_WIDTH-1:0]    rg_wrt_data_o,
    output logic                     alu_stall_o,
`ifdef WB_FWD_EN
    input  logic [ADDRESS_WIDTH-1:0] fwd_addr1_i,
    input  logic [ADDRESS_WIDTH-1:0] fwd_addr2_i,
    output logic                     fwd_hit1_o,
    output logic                     fwd_hit2_o,
    output logic [DATA_WIDTH-1:0]    fwd_data1_o,
    output logic [DATA_WIDTH-1:0]    fwd_data2_o,
`endif
    output logic [NUM_REGS-1:0]      pending_mask_o
);

    localparam int unsigned CntW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    wb_entry_t mc_entry, alu_entry, head, sel_entry;
    logic [1:0] sel;
    logic       fifo_full, fifo_empty, mc_acc, push, pop;
    logic [FIFO_DEPTH-1:0]                    entry_valid;
    logic [FIFO_DEPTH-1:0][ADDRESS_WIDTH-1:0] entry_dest;

    logic                     en_q, en_d;
    logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     stall_q, stall_d;

    assign mc_entry.dest  = mc_wb_dest_i;
    assign mc_entry.data  = mc_wb_data_i;
    assign alu_entry.dest = alu_wb_dest_i;
    assign alu_entry.data = alu_wb_data_i;

    // Ready depends only on state so upstream can compute valid from it without a loop.
    assign mc_wb_ready_o = rst_ni & ~fifo_full;
    assign mc_acc        = mc_wb_valid_i & mc_wb_ready_o;

    always_comb begin
        sel       = SEL_NONE;
        sel_entry = head;
        if (alu_wb_valid_i) begin
            sel       = SEL_ALU;
            sel_entry = alu_entry;
        end else if (!fifo_empty) begin
            sel       = SEL_FIFO;
            sel_entry = head;
        end else if (mc_acc) begin
            sel       = SEL_BYP;
            sel_entry = mc_entry;
        end
    end

    assign push = mc_acc & (sel != SEL_BYP);
    assign pop  = (sel == SEL_FIFO);

    always_comb begin
        en_d    = (sel != SEL_NONE) && (sel_entry.dest != '0);
        dest_d  = dest_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        if (sel != SEL_NONE) begin
            dest_d = sel_entry.dest;
            data_d = sel_entry.data;
        end
        if (pop || fifo_empty) begin
            cnt_d = '0;
        end else if (sel == SEL_ALU) begin
            if (cnt_q == CntW'(STARVE_LIMIT - 1)) begin
                stall_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q    <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (push),
        .push_entry_i  (mc_entry),
        .pop_i         (pop),
        .head_o        (head),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .entry_valid_o (entry_valid),
        .entry_dest_o  (entry_dest)
    );

    always_comb begin
        pending_mask_o = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (entry_valid[e] && entry_dest[e] == ADDRESS_WIDTH'(r)) begin
                    pending_mask_o[r] = 1'b1;
                end
            end
        end
    end

    assign rg_wrt_en_o   = en_q;
    assign rg_wrt_dest_o = dest_q;
    assign rg_wrt_data_o = data_q;
    assign alu_stall_o   = stall_q;

`ifdef WB_FWD_EN
    assign fwd_hit1_o  = en_q && (dest_q == fwd_addr1_i) && (fwd_addr1_i != '0);
    assign fwd_hit2_o  = en_q && (dest_q == fwd_addr2_i) && (fwd_addr2_i != '0);
    assign fwd_data1_o = data_q;
    assign fwd_data2_o = data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expected values.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_dest;
    logic [31:0] mc_data;
    logic        wr_en;
    logic [4:0]  wr_dest;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] mask;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_addr1 = 5'd0;
    logic [4:0]  fwd_addr2 = 5'd0;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .alu_wb_valid_i(alu_valid),
        .alu_wb_dest_i (alu_dest),
        .alu_wb_data_i (alu_data),
        .mc_wb_valid_i (mc_valid),
        .mc_wb_ready_o (mc_ready),
        .mc_wb_dest_i  (mc_dest),
        .mc_wb_data_i  (mc_data),
        .rg_wrt_en_o   (wr_en),
        .rg_wrt_dest_o (wr_dest),
        .rg_wrt_data_o (wr_data),
        .alu_stall_o   (stall),
`ifdef WB_FWD_EN
        .fwd_addr1_i   (fwd_addr1),
        .fwd_addr2_i   (fwd_addr2),
        .fwd_hit1_o    (fwd_hit1),
        .fwd_hit2_o    (fwd_hit2),
        .fwd_data1_o   (fwd_data1),
        .fwd_data2_o   (fwd_data2),
`endif
        .pending_mask_o(mask)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ad, input logic mv,
                         input logic [4:0] md);
        alu_valid = av;
        alu_dest  = ad;
        alu_data  = 32'hA000 + 32'(ad);
        mc_valid  = mv;
        mc_dest   = md;
        mc_data   = 32'hB000 + 32'(md);
    endtask

    task automatic expect_wr(input string tag, input logic en, input logic [4:0] d,
                             input logic [31:0] v);
        check_eq({tag, ".en"}, 32'(wr_en), 32'(en));
        if (en) begin
            check_eq({tag, ".dest"}, 32'(wr_dest), 32'(d));
            check_eq({tag, ".data"}, wr_data, v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        step();
        step();
        check_eq("rst.en", 32'(wr_en), 32'd0);
        check_eq("rst.dest", 32'(wr_dest), 32'd0);
        check_eq("rst.data", wr_data, 32'd0);
        check_eq("rst.ready", 32'(mc_ready), 32'd0);
        check_eq("rst.stall", 32'(stall), 32'd0);
        check_eq("rst.mask", mask, 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("idle.ready", 32'(mc_ready), 32'd1);
        expect_wr("idle", 1'b0, 5'd0, 32'd0);

        // ALU only
        alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEAD_BEEF;
        step();
        expect_wr("alu", 1'b1, 5'd5, 32'hDEAD_BEEF);
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        step();
        expect_wr("alu.after", 1'b0, 5'd0, 32'd0);

        // mc bypass with empty FIFO
        mc_valid = 1'b1; mc_dest = 5'd7; mc_data = 32'h1234;
        step();
        expect_wr("byp", 1'b1, 5'd7, 32'h1234);
        check_eq("byp.mask", mask, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        step();

        // ALU and mc together: ALU first, mc queued one cycle
        drive(1'b1, 5'd3, 1'b1, 5'd9);
        step();
        expect_wr("both.alu", 1'b1, 5'd3, 32'hA003);
        check_eq("both.mask", mask, 32'h0000_0200);
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        step();
        expect_wr("both.mc", 1'b1, 5'd9, 32'hB009);
        check_eq("both.mask0", mask, 32'd0);
        step();
        expect_wr("both.idle", 1'b0, 5'd0, 32'd0);

        // Fill FIFO under continuous ALU traffic, then starvation bubble
        drive(1'b1, 5'd1, 1'b1, 5'd10);
        step();
        expect_wr("fill.a", 1'b1, 5'd1, 32'hA001);
        check_eq("fill.a.mask", mask, 32'h0000_0400);
        check_eq("fill.a.ready", 32'(mc_ready), 32'd1);
        drive(1'b1, 5'd2, 1'b1, 5'd11);
        step();
        check_eq("fill.b.ready", 32'(mc_ready), 32'd0);
        check_eq("fill.b.mask", mask, 32'h0000_0C00);
        check_eq("fill.b.stall", 32'(stall), 32'd0);
        drive(1'b1, 5'd3, 1'b1, 5'd12);
        step();
        check_eq("fill.c.stall", 32'(stall), 32'd0);
        check_eq("fill.c.mask", mask, 32'h0000_0C00);
        drive(1'b1, 5'd4, 1'b1, 5'd12);
        step();
        check_eq("fill.d.stall", 32'(stall), 32'd0);
        drive(1'b1, 5'd5, 1'b1, 5'd12);
        step();
        check_eq("fill.e.stall", 32'(stall), 32'd1);
        expect_wr("fill.e", 1'b1, 5'd5, 32'hA005);
        drive(1'b0, 5'd0, 1'b1, 5'd12);
        step();
        expect_wr("bubble", 1'b1, 5'd10, 32'hB00A);
        check_eq("bubble.stall", 32'(stall), 32'd0);
        check_eq("bubble.mask", mask, 32'h0000_0800);
        check_eq("bubble.ready", 32'(mc_ready), 32'd1);
        drive(1'b1, 5'd6, 1'b1, 5'd12);
        step();
        expect_wr("fill.g", 1'b1, 5'd6, 32'hA006);
        check_eq("fill.g.mask", mask, 32'h0000_1800);
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        step();
        expect_wr("drain.11", 1'b1, 5'd11, 32'hB00B);
        step();
        expect_wr("drain.12", 1'b1, 5'd12, 32'hB00C);
        check_eq("drain.mask", mask, 32'd0);
        step();
        expect_wr("drain.idle", 1'b0, 5'd0, 32'd0);

        // x0 writes from each path are dropped but consumed
        drive(1'b1, 5'd0, 1'b0, 5'd0);
        step();
        expect_wr("x0.alu", 1'b0, 5'd0, 32'd0);
        drive(1'b0, 5'd0, 1'b1, 5'd0);
        step();
        expect_wr("x0.byp", 1'b0, 5'd0, 32'd0);
        check_eq("x0.byp.mask", mask, 32'd0);
        drive(1'b1, 5'd2, 1'b1, 5'd0);
        step();
        expect_wr("x0.q.alu", 1'b1, 5'd2, 32'hA002);
        check_eq("x0.q.mask", mask, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        step();
        expect_wr("x0.pop", 1'b0, 5'd0, 32'd0);
        drive(1'b0, 5'd0, 1'b1, 5'd13);
        step();
        expect_wr("x0.next", 1'b1, 5'd13, 32'hB00D);
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        step();

        // Async reset with two entries queued
        drive(1'b1, 5'd1, 1'b1, 5'd20);
        step();
        drive(1'b1, 5'd2, 1'b1, 5'd21);
        step();
        check_eq("prerst.mask", mask, 32'h0030_0000);
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.en", 32'(wr_en), 32'd0);
        check_eq("arst.mask", mask, 32'd0);
        check_eq("arst.ready", 32'(mc_ready), 32'd0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        expect_wr("postrst.a", 1'b0, 5'd0, 32'd0);
        check_eq("postrst.mask", mask, 32'd0);
        check_eq("postrst.ready", 32'(mc_ready), 32'd1);
        step();
        expect_wr("postrst.b", 1'b0, 5'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
